// File: rtl/blowfish_pkg.sv
// Shared constants and types for the Blowfish P-array loader.
//   P_WORDS  : subkey words per key schedule
//   WORD_W   : subkey word width
//   IDX_W    : width of a P-array index
//   state_t  : loader FSM states
//   p_wr_t   : register-file write port payload
package blowfish_pkg;

  localparam int unsigned P_WORDS = 18;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned IDX_W   = 5;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(P_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    READY = 2'd2
  } state_t;

  typedef struct packed {
    logic              we;
    logic [IDX_W-1:0]  addr;
    logic [WORD_W-1:0] data;
  } p_wr_t;

endpackage

// File: rtl/blowfish_p_regfile.sv
// 18 x 32 subkey register file: one write port in key-schedule order and one
// registered read port addressed in decrypt order (index k returns P[17-k]).
//   clk, reset : clock, async active-low reset (clears all words)
//   wr         : write port (we, addr, data)
//   rd_addr    : decrypt-order index k
//   rd_data    : registered P[17-k], zero for k > 17
module blowfish_p_regfile
  import blowfish_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  p_wr_t             wr,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [P_WORDS];

  // Storage; out-of-range write addresses are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < P_WORDS; i++) mem[i] <= '0;
    end else if (wr.we && (wr.addr <= LAST_IDX)) begin
      mem[wr.addr] <= wr.data;
    end
  end

  // Reversed read; the range check keeps the 5-bit subtract from wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_addr <= LAST_IDX) begin
      rd_data <= mem[LAST_IDX - rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/blowfish_p_loader.sv
// Pops the 18 expanded subkeys from the encrypt->decrypt FIFO into a local
// register file and serves them to the decrypt core in reverse order.
//   clk, reset        : clock, async active-low reset
//   encrypt_init_done : rising edge arms a load (also restarts from READY)
//   abort_blowfish    : synchronous abort to IDLE, level-sensitive
//   fifo_empty        : FIFO empty flag
//   fifo_dout         : FIFO data, valid the cycle after fifo_rd_en
//   fifo_rd_en        : FIFO pop request (never while empty)
//   p_rd_addr         : decrypt-order index k
//   p_rd_data         : registered P[17-k]
//   p_valid           : all 18 words loaded
//   loading           : load in progress
module blowfish_p_loader
  import blowfish_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              encrypt_init_done,
  input  logic              abort_blowfish,
  input  logic              fifo_empty,
  input  logic [WORD_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  input  logic [IDX_W-1:0]  p_rd_addr,
  output logic [WORD_W-1:0] p_rd_data,
  output logic              p_valid,
  output logic              loading
);

  state_t            state;
  state_t            next_state;
  logic              init_prev;
  logic              init_rise;
  logic              start;
  logic [IDX_W-1:0]  issue_cnt;
  logic [IDX_W-1:0]  cap_cnt;
  logic              cap_flag;
  p_wr_t             wr;

  assign init_rise = encrypt_init_done & ~init_prev;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next state; abort overrides any arm edge.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (init_rise) begin
          next_state = FETCH;
          start      = 1'b1;
        end
      end
      FETCH: begin
        if (cap_flag && (cap_cnt == LAST_IDX)) next_state = READY;
      end
      READY: begin
        if (init_rise) begin
          next_state = FETCH;
          start      = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
    if (abort_blowfish) begin
      next_state = IDLE;
      start      = 1'b0;
    end
  end

  // Outputs decoded from state; a capture pending during abort is dropped.
  always_comb begin
    fifo_rd_en = 1'b0;
    p_valid    = 1'b0;
    loading    = 1'b0;
    wr         = '0;
    case (state)
      FETCH: begin
        loading    = 1'b1;
        fifo_rd_en = !fifo_empty && (issue_cnt < IDX_W'(P_WORDS));
        wr.we      = cap_flag && !abort_blowfish;
        wr.addr    = cap_cnt;
        wr.data    = fifo_dout;
      end
      READY:   p_valid = 1'b1;
      default: ;
    endcase
  end

  // Edge detect, pop/capture counters and the one-cycle capture flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      init_prev <= 1'b0;
      issue_cnt <= '0;
      cap_cnt   <= '0;
      cap_flag  <= 1'b0;
    end else begin
      init_prev <= encrypt_init_done;
      if (abort_blowfish || start) begin
        issue_cnt <= '0;
        cap_cnt   <= '0;
        cap_flag  <= 1'b0;
      end else if (state == FETCH) begin
        if (fifo_rd_en) issue_cnt <= issue_cnt + IDX_W'(1);
        if (cap_flag)   cap_cnt   <= cap_cnt + IDX_W'(1);
        cap_flag <= fifo_rd_en;
      end else begin
        cap_flag <= 1'b0;
      end
    end
  end

  blowfish_p_regfile u_regfile (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr),
    .rd_addr (p_rd_addr),
    .rd_data (p_rd_data)
  );

endmodule

// File: tb/tb_blowfish_p_loader.sv
// Scoreboard bench for blowfish_p_loader: behavioural FIFO, list-based
// reference of the loaded words, decoupled read-data and load-timing monitors.
module tb_blowfish_p_loader;

  logic        clk;
  logic        reset;
  logic        encrypt_init_done;
  logic        abort_blowfish;
  logic        fifo_empty;
  logic [31:0] fifo_dout;
  logic        fifo_rd_en;
  logic [4:0]  p_rd_addr;
  logic [31:0] p_rd_data;
  logic        p_valid;
  logic        loading;

  blowfish_p_loader dut (
    .clk               (clk),
    .reset             (reset),
    .encrypt_init_done (encrypt_init_done),
    .abort_blowfish    (abort_blowfish),
    .fifo_empty        (fifo_empty),
    .fifo_dout         (fifo_dout),
    .fifo_rd_en        (fifo_rd_en),
    .p_rd_addr         (p_rd_addr),
    .p_rd_data         (p_rd_data),
    .p_valid           (p_valid),
    .loading           (loading)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        v;
  } exp_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          gen   = 0;
  logic [31:0] fifo_q[$];
  logic [31:0] model[$];
  exp_t        exp_q[$];
  logic        rd_issue = 1'b0;
  logic        armed    = 1'b0;
  logic        pop_req  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Standard-mode FIFO: a pop requested in a cycle presents data after the edge.
  always @(negedge clk) pop_req = fifo_rd_en;
  always begin
    @(posedge clk);
    if (pop_req && fifo_q.size() > 0) begin
      #1;
      fifo_dout  = fifo_q.pop_front();
      fifo_empty = (fifo_q.size() == 0);
    end
  end

  // Read-data monitor: one-cycle latency from an issued address.
  always @(posedge clk) armed = rd_issue;
  always @(negedge clk) begin
    if (armed) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("p_rd_data", p_rd_data, e.d);
        chk("p_valid_on_read", 32'(p_valid), 32'(e.v));
      end
    end
  end

  // Load monitor: no underflow, at most 18 pops per arm, p_valid two cycles
  // after the 18th pop.
  int seen_gen = 0;
  int pop_cnt  = 0;
  int due      = -1;
  always @(negedge clk) begin
    if (gen != seen_gen) begin
      seen_gen = gen;
      pop_cnt  = 0;
      due      = -1;
    end
    if (fifo_rd_en) begin
      chk("no_underflow", 32'(fifo_empty), 32'd0);
      if (pop_cnt >= 18) chk("pops_per_load", 32'(pop_cnt + 1), 32'd18);
      pop_cnt++;
      if (pop_cnt == 18) due = cyc + 2;
    end
    if (due > 0 && cyc == due - 1) begin
      chk("valid_before_due", 32'(p_valid), 32'd0);
      chk("loading_before_due", 32'(loading), 32'd1);
    end else if (due > 0 && cyc == due) begin
      chk("valid_at_due", 32'(p_valid), 32'd1);
      chk("loading_at_due", 32'(loading), 32'd0);
      due = -1;
    end
  end

  function automatic logic [31:0] ref_read(input int k);
    return (k < 18) ? model[17 - k] : 32'h0;
  endfunction

  task automatic push_word(input logic [31:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic flush_fifo();
    fifo_q.delete();
    fifo_empty = 1'b1;
  endtask

  // Push n words; the first 18 become the reference key schedule.
  task automatic load_fifo(input int n, input bit seq);
    model.delete();
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      w = seq ? 32'(i) : $urandom();
      push_word(w);
      if (i < 18) model.push_back(w);
    end
  endtask

  task automatic arm(output int first_pop);
    @(negedge clk) encrypt_init_done = 1'b0;
    @(negedge clk) encrypt_init_done = 1'b1;
    gen++;
    @(negedge clk);
    chk("first_pop_e_plus_1", 32'(fifo_rd_en), 32'd1);
    chk("loading_in_fetch", 32'(loading), 32'd1);
    first_pop = cyc;
  endtask

  task automatic wait_valid(output int vc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!p_valid && n < 200);
    if (!p_valid) chk("valid_timeout", 32'(p_valid), 32'd1);
    vc = cyc;
  endtask

  task automatic rd(input int a);
    exp_t e;
    @(negedge clk);
    p_rd_addr = 5'(a);
    rd_issue  = 1'b1;
    e.d = ref_read(a);
    e.v = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic rd_end();
    @(negedge clk);
    rd_issue = 1'b0;
  endtask

  task automatic rd_all();
    for (int a = 0; a < 18; a++) rd(a);
    rd_end();
  endtask

  initial begin
    int t0;
    int vc;
    int n;
    reset             = 1'b0;
    encrypt_init_done = 1'b0;
    abort_blowfish    = 1'b0;
    fifo_empty        = 1'b1;
    fifo_dout         = '0;
    p_rd_addr         = '0;

    repeat (3) @(negedge clk);
    chk("rst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_p_rd_data", p_rd_data, 32'd0);
    chk("rst_p_valid", 32'(p_valid), 32'd0);
    chk("rst_loading", 32'(loading), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Sequential key schedule 0..17.
    load_fifo(18, 1'b1);
    arm(t0);
    wait_valid(vc);
    chk("valid_latency", 32'(vc), 32'(t0 + 19));
    rd(0);
    rd(17);
    for (int a = 18; a < 32; a++) rd(a);
    rd_end();

    // Restart from READY with 20 words queued: 2 must remain.
    load_fifo(20, 1'b0);
    arm(t0);
    wait_valid(vc);
    chk("valid_latency_20", 32'(vc), 32'(t0 + 19));
    repeat (4) begin
      @(negedge clk);
      chk("no_pop_in_ready", 32'(fifo_rd_en), 32'd0);
    end
    chk("fifo_leftover", 32'(fifo_q.size()), 32'd2);
    chk("fifo_not_empty", 32'(fifo_empty), 32'd0);
    for (int i = 0; i < 20; i++) rd(int'($urandom_range(0, 31)));
    rd_end();
    flush_fifo();

    // FIFO runs dry after word 8 for five cycles.
    model.delete();
    for (int i = 0; i < 18; i++) model.push_back($urandom());
    for (int i = 0; i < 9; i++) push_word(model[i]);
    arm(t0);
    n = 0;
    while (!fifo_empty && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("fifo_drained", 32'(fifo_empty), 32'd1);
    repeat (5) begin
      chk("gap_no_pop", 32'(fifo_rd_en), 32'd0);
      chk("gap_loading", 32'(loading), 32'd1);
      @(negedge clk);
    end
    for (int i = 9; i < 18; i++) push_word(model[i]);
    wait_valid(vc);
    chk("valid_latency_gap", 32'(vc), 32'(t0 + 24));
    rd_all();

    // Abort after ten captures, then reload fresh words.
    load_fifo(18, 1'b0);
    arm(t0);
    n = 1;
    while (n < 11) begin
      @(negedge clk);
      if (fifo_rd_en) n++;
    end
    @(negedge clk) abort_blowfish = 1'b1;
    @(negedge clk) abort_blowfish = 1'b0;
    gen++;
    chk("abort_p_valid", 32'(p_valid), 32'd0);
    chk("abort_loading", 32'(loading), 32'd0);
    chk("abort_rd_en", 32'(fifo_rd_en), 32'd0);
    flush_fifo();
    load_fifo(18, 1'b0);
    arm(t0);
    wait_valid(vc);
    chk("valid_latency_rearm", 32'(vc), 32'(t0 + 19));
    rd_all();

    // Asynchronous reset between edges in the middle of a load.
    load_fifo(18, 1'b0);
    arm(t0);
    n = 1;
    while (n < 5) begin
      @(negedge clk);
      if (fifo_rd_en) n++;
    end
    @(posedge clk);
    #3;
    reset             = 1'b0;
    encrypt_init_done = 1'b0;
    #1;
    gen++;
    chk("async_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("async_rst_loading", 32'(loading), 32'd0);
    chk("async_rst_p_valid", 32'(p_valid), 32'd0);
    chk("async_rst_p_rd_data", p_rd_data, 32'd0);
    @(negedge clk);
    flush_fifo();
    load_fifo(18, 1'b0);
    @(negedge clk) reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("no_pop_without_edge", 32'(fifo_rd_en), 32'd0);
    end
    arm(t0);
    wait_valid(vc);
    chk("valid_latency_post_rst", 32'(vc), 32'(t0 + 19));
    rd_all();

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
